// File: rtl/xc_sched_pkg.sv
// xc_sched_pkg: shared FSM state type and default sizing for xc_scheduler
package xc_sched_pkg;
  localparam int DEF_MUX_LINES = 4;
  localparam int DEF_LEN_WIDTH = 24;
  localparam int DEF_SETTLE_CYCLES = 8;
  typedef enum logic [2:0] {IDLE, SETTLE, INTEGRATE, READOUT, ADVANCE} state_t;
endpackage

// File: rtl/xc_rr_pick.sv
// xc_rr_pick: next set mask bit strictly above cur, wrapping round-robin (cur itself last)
module xc_rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] nxt,
  output logic          valid
);
  logic [IW-1:0] j;
  // scan offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    nxt = cur;
    valid = 1'b0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(cur) + k) % N);
      if (mask[j]) begin
        nxt = j;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xc_scheduler.sv
// xc_scheduler: mux-group sequencer for the correlator; XC_SCHED_OVERRUN_EN enables sticky overrun detection
module xc_scheduler
  import xc_sched_pkg::*;
#(
  parameter int MUX_LINES = DEF_MUX_LINES,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         sample_tick,
  input  logic [LEN_WIDTH-1:0]         integration_len,
  input  logic [MUX_LINES-1:0]         mux_mask,
  input  logic                         readout_ack,
  output logic [MUX_LINES-1:0]         mux_out,
  output logic                         integrating,
  output logic [$clog2(MUX_LINES)-1:0] window_index,
  output logic                         readout_req,
  output logic                         overrun
);
  localparam int IW = $clog2(MUX_LINES);
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  state_t state, next_state;
  logic [IW-1:0] next_idx, pick, pick_from;
  logic pick_valid, load;
  logic [SW-1:0] settle_cnt;
  logic [LEN_WIDTH-1:0] tick_cnt, len_last;
  // from IDLE the search starts above the top line so the lowest set bit is chosen
  assign pick_from = state == IDLE ? IW'(MUX_LINES - 1) : window_index;
  xc_rr_pick #(.N(MUX_LINES), .IW(IW)) u_pick (
    .mask(mux_mask),
    .cur(pick_from),
    .nxt(pick),
    .valid(pick_valid)
  );
  // next-state selection; group and length are captured only when entering SETTLE
  always_comb begin
    next_state = state;
    next_idx = window_index;
    load = 1'b0;
    if (!enable) next_state = IDLE;
    else
      case (state)
        IDLE, ADVANCE: begin
          next_state = pick_valid ? SETTLE : IDLE;
          next_idx = pick_valid ? pick : window_index;
          load = pick_valid;
        end
        SETTLE: next_state = settle_cnt == SW'(SETTLE_CYCLES - 1) ? INTEGRATE : SETTLE;
        INTEGRATE: next_state = sample_tick && tick_cnt == len_last ? READOUT : INTEGRATE;
        READOUT: next_state = readout_ack ? ADVANCE : READOUT;
        default: next_state = IDLE;
      endcase
  end
  // state, counters and outputs registered from the next state so outputs track state exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      window_index <= '0;
      mux_out <= '0;
      integrating <= 1'b0;
      readout_req <= 1'b0;
      settle_cnt <= '0;
      tick_cnt <= '0;
      len_last <= '0;
    end else begin
      state <= next_state;
      window_index <= next_idx;
      mux_out <= next_state == IDLE ? '0 : MUX_LINES'(1) << next_idx;
      integrating <= next_state == INTEGRATE;
      readout_req <= next_state == READOUT;
      settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
      tick_cnt <= state == INTEGRATE ? tick_cnt + LEN_WIDTH'(sample_tick) : '0;
      len_last <= load ? (integration_len == '0 ? '0 : integration_len - LEN_WIDTH'(1)) : len_last;
    end
  end
`ifdef XC_SCHED_OVERRUN_EN
  logic enable_q;
  // sticky flag for ticks lost while waiting on readout; a fresh enable rise clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      enable_q <= enable;
      overrun <= (enable && !enable_q) ? 1'b0 : overrun | (state == READOUT && sample_tick);
    end
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_xc_scheduler.sv
// tb_xc_scheduler: table-driven and scoreboard checks of xc_scheduler sequencing, abort, reset and overrun
module tb_xc_scheduler;
  localparam int ML = 4;
  localparam int LW = 8;
  localparam int SC = 4;
`ifdef XC_SCHED_OVERRUN_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif
  logic clk = 1'b0;
  logic reset_n, enable, sample_tick, readout_ack, integrating, readout_req, overrun;
  logic [LW-1:0] integration_len;
  logic [ML-1:0] mux_mask, mux_out;
  logic [1:0] window_index;
  typedef struct packed {logic [3:0] mux; logic [1:0] idx; logic [7:0] ticks;} sb_t;
  typedef struct packed {logic [3:0] mask; logic [7:0] len; logic [15:0] seq;} vec_t;
  sb_t exp_q[$];
  vec_t vecs[5];
  vec_t v;
  int checks = 0, errors = 0, windows_done = 0, target = 0;
  bit auto_ack = 0, tick_en = 0, sb_on = 0;

  always #5 clk = ~clk;

  xc_scheduler #(.MUX_LINES(ML), .LEN_WIDTH(LW), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_tick(sample_tick),
    .integration_len(integration_len), .mux_mask(mux_mask), .readout_ack(readout_ack),
    .mux_out(mux_out), .integrating(integrating), .window_index(window_index),
    .readout_req(readout_req), .overrun(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] m);
    oh2i = '0;
    for (int i = 0; i < 4; i++) if (m[i]) oh2i = 2'(i);
  endfunction

  task automatic push(input logic [3:0] m, input logic [7:0] len);
    sb_t e;
    e.mux = m;
    e.idx = oh2i(m);
    e.ticks = (len == 0) ? 8'd1 : len;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int what, input int tgt, input string name);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      ok = (what == 0) ? integrating : (what == 1) ? readout_req : (windows_done >= tgt);
      if (!ok) step(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_%s: condition not reached within 3000 cycles", name);
    end
  endtask

  task automatic monitor();
    int ticks = 0;
    logic req_prev = 1'b0;
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ticks = 0;
        req_prev = 1'b0;
      end else begin
        if (readout_req && !req_prev) begin
          windows_done++;
          if (sb_on) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty: window on %b, expected none", mux_out);
            end else begin
              e = exp_q.pop_front();
              chk("win_mux", int'(mux_out), int'(e.mux));
              chk("win_idx", int'(window_index), int'(e.idx));
              chk("win_ticks", ticks, int'(e.ticks));
            end
          end
        end
        if (!integrating) ticks = 0;
        if (integrating && sample_tick) ticks++;
        req_prev = readout_req;
      end
    end
  endtask

  task automatic ack_loop();
    int n = 0;
    forever begin
      step(1);
      if (auto_ack) begin
        if (readout_req && !readout_ack) begin
          n++;
          if (n == 2) begin
            readout_ack = 1'b1;
            n = 0;
          end
        end else begin
          readout_ack = 1'b0;
          n = 0;
        end
      end
    end
  endtask

  task automatic tick_loop();
    int ph = 0;
    forever begin
      step(1);
      if (tick_en) begin
        sample_tick = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  endtask

  initial begin
    reset_n = 0; enable = 0; sample_tick = 0; readout_ack = 0;
    integration_len = '0; mux_mask = '0;
    vecs[0] = '{mask: 4'b1011, len: 8'd3, seq: 16'h1821};
    vecs[1] = '{mask: 4'b0100, len: 8'd0, seq: 16'h4444};
    vecs[2] = '{mask: 4'b1100, len: 8'd2, seq: 16'h8484};
    vecs[3] = '{mask: 4'b1111, len: 8'd1, seq: 16'h8421};
    vecs[4] = '{mask: 4'b1001, len: 8'd5, seq: 16'h8181};
    fork
      monitor();
      ack_loop();
      tick_loop();
    join_none
    step(2);
    chk("rst_mux", int'(mux_out), 0);
    chk("rst_int", int'(integrating), 0);
    chk("rst_idx", int'(window_index), 0);
    chk("rst_req", int'(readout_req), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset_n = 1;
    enable = 1;
    step(3);
    chk("mask0_idle_mux", int'(mux_out), 0);
    chk("mask0_idle_int", int'(integrating), 0);
    enable = 0;
    step(1);
    sb_on = 1; auto_ack = 1; tick_en = 1;
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      enable = 0;
      step(2);
      mux_mask = v.mask;
      integration_len = v.len;
      for (int k = 0; k < 4; k++) push(v.seq[4*k +: 4], v.len);
      target = windows_done + 4;
      enable = 1;
      wait_until(2, target, "vec_windows");
      enable = 0;
      step(2);
      chk("sb_drained", exp_q.size(), 0);
      exp_q.delete();
    end
    mux_mask = 4'b0101;
    integration_len = 8'd3;
    push(4'b0001, 8'd3);
    target = windows_done + 3;
    enable = 1;
    wait_until(0, 0, "int_mask_change");
    mux_mask = 4'b0010;
    push(4'b0010, 8'd3);
    push(4'b0010, 8'd3);
    wait_until(2, target, "mask_change_windows");
    enable = 0;
    step(2);
    chk("sb_drained_mask", exp_q.size(), 0);
    exp_q.delete();
    sb_on = 0; auto_ack = 0; tick_en = 0;
    sample_tick = 0; readout_ack = 0;
    step(1);
    mux_mask = 4'b0001;
    integration_len = 8'd0;
    enable = 1;
    step(1);
    chk("settle_mux", int'(mux_out), 1);
    chk("settle_int", int'(integrating), 0);
    wait_until(0, 0, "int_len0");
    readout_ack = 1;
    step(1);
    readout_ack = 0;
    chk("stray_ack_int", int'(integrating), 1);
    chk("stray_ack_req", int'(readout_req), 0);
    step(3);
    chk("no_tick_hold", int'(integrating), 1);
    sample_tick = 1;
    step(1);
    sample_tick = 0;
    chk("len0_int_drop", int'(integrating), 0);
    chk("len0_req", int'(readout_req), 1);
    chk("ovr_before", int'(overrun), 0);
    step(3);
    chk("req_hold", int'(readout_req), 1);
    chk("req_mux_hold", int'(mux_out), 1);
    sample_tick = 1;
    step(2);
    sample_tick = 0;
    step(1);
    chk("ovr_set", int'(overrun), EXP_OVR);
    readout_ack = 1;
    step(1);
    readout_ack = 0;
    chk("req_drop", int'(readout_req), 0);
    step(1);
    chk("single_reselect", int'(mux_out), 1);
    mux_mask = 4'b0011;
    wait_until(0, 0, "int_abort");
    step(1);
    enable = 0;
    step(1);
    chk("abort_mux", int'(mux_out), 0);
    chk("abort_int", int'(integrating), 0);
    chk("abort_req", int'(readout_req), 0);
    chk("ovr_hold_disabled", int'(overrun), EXP_OVR);
    enable = 1;
    step(1);
    chk("ovr_clear", int'(overrun), 0);
    chk("restart_mux", int'(mux_out), 1);
    wait_until(0, 0, "int_g0");
    sample_tick = 1;
    step(1);
    sample_tick = 0;
    chk("req_g0", int'(readout_req), 1);
    readout_ack = 1;
    step(1);
    readout_ack = 0;
    step(1);
    chk("adv_mux_g1", int'(mux_out), 2);
    chk("adv_idx_g1", int'(window_index), 1);
    wait_until(0, 0, "int_g1");
    sample_tick = 1;
    step(1);
    sample_tick = 0;
    chk("req_g1", int'(readout_req), 1);
    enable = 0;
    readout_ack = 1;
    step(1);
    readout_ack = 0;
    chk("abort_ack_mux", int'(mux_out), 0);
    chk("abort_ack_int", int'(integrating), 0);
    chk("abort_ack_req", int'(readout_req), 0);
    chk("no_advance_idx", int'(window_index), 1);
    enable = 1;
    step(1);
    chk("restart_low_mux", int'(mux_out), 1);
    chk("restart_low_idx", int'(window_index), 0);
    enable = 0;
    step(1);
    mux_mask = 4'b0110;
    enable = 1;
    step(1);
    chk("settle_rst_mux", int'(mux_out), 2);
    step(1);
    #2 reset_n = 0;
    #1;
    chk("async_rst_mux", int'(mux_out), 0);
    chk("async_rst_idx", int'(window_index), 0);
    chk("async_rst_int", int'(integrating), 0);
    chk("async_rst_req", int'(readout_req), 0);
    @(posedge clk);
    #3 reset_n = 1;
    step(1);
    chk("post_rst_mux", int'(mux_out), 2);
    chk("post_rst_idx", int'(window_index), 1);
    step(SC - 1);
    chk("settle_len_lo", int'(integrating), 0);
    step(1);
    chk("settle_len_hi", int'(integrating), 1);
    enable = 0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xc_scheduler.md
XC_SCHEDULER -- requirements
Module: xc_scheduler

Interface
REQ-001 SHALL have parameter MUX_LINES, default 4, number of mux groups sequenced (2..16).
REQ-002 SHALL have parameter LEN_WIDTH, default 24, width of integration length in sample ticks.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, clk cycles of blanking after each mux switch (>=1).
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  run request (already synchronised to clk).
REQ-007 SHALL have port sample_tick  in  1  one-cycle pulse per sampling_clk period.
REQ-008 SHALL have port integration_len  in  LEN_WIDTH  sample ticks per window.
REQ-009 SHALL have port mux_mask  in  MUX_LINES  1 = group included in rotation.
REQ-010 SHALL have port readout_ack  in  1  downstream (UART packer) accepted the window.
REQ-011 SHALL have port mux_out  out  MUX_LINES  one-hot active group, 0 when idle.
REQ-012 SHALL have port integrating  out  1  high while correlator accumulates.
REQ-013 SHALL have port window_index  out  $clog2(MUX_LINES)  index of current group.
REQ-014 SHALL have port readout_req  out  1  window complete, results valid, awaiting ack.
REQ-015 SHALL have port overrun  out  1  sticky: sample ticks lost during readout.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, INTEGRATE, READOUT, ADVANCE.
REQ-017 IDLE->SETTLE SHALL occur the cycle after enable=1 and mux_mask!=0; first group = lowest set mask bit.
REQ-018 SHALL latch integration_len and mux_mask on every entry to SETTLE; mid-window changes have no effect.
REQ-019 integration_len=0 SHALL be treated as 1.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES clk cycles with mux_out driven and integrating=0, then enter INTEGRATE.
REQ-021 INTEGRATE SHALL assert integrating and count sample_tick pulses; on the tick that reaches the latched length, integrating SHALL drop the next cycle and state SHALL enter READOUT.
REQ-022 READOUT SHALL hold readout_req=1, mux_out and window_index stable until readout_ack=1 sampled; req SHALL drop the cycle after ack.
REQ-023 readout_ack outside READOUT SHALL be ignored.
REQ-024 ADVANCE SHALL select the next set mask bit above current, wrapping round-robin to the lowest; single-bit mask reselects the same group; then SETTLE.
REQ-025 ADVANCE with latched mask now 0 (fresh mux_mask=0) SHALL return to IDLE.
REQ-026 enable=0 in any state SHALL force IDLE next cycle, clearing mux_out, integrating, readout_req; abort wins over simultaneous readout_ack.
REQ-027 Tick counter SHALL be LEN_WIDTH bits and never wrap; a tick coinciding with state entry SHALL count only in INTEGRATE.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, mux_out=0, integrating=0, window_index=0, readout_req=0, overrun=0, counters=0.
REQ-030 Reset release mid-operation SHALL restart from IDLE; no partial window resumed.

Configuration
REQ-031 Macro XC_SCHED_OVERRUN_EN defined: any sample_tick while in READOUT SHALL set overrun, cleared only by reset or enable 0->1 transition.
REQ-032 Macro undefined: overrun SHALL be tied 0 and its detection logic absent.

Structure
REQ-033 Package xc_sched_pkg SHALL hold the FSM state enum and SETTLE_CYCLES/LEN_WIDTH defaults.
REQ-034 Round-robin next-bit selection SHALL be sub-module xc_rr_pick (mask, current index -> next index, valid).

Verification
REQ-035 MUX_LINES=4, mask=4'b1011, len=3, ack 2 cycles after req: mux_out sequence 0001,0010,1000,0001; integrating high for exactly 3 ticks each window.
REQ-036 len=0: window closes after 1 tick; readout_req rises one cycle later.
REQ-037 enable dropped during INTEGRATE and again same cycle as readout_ack: all outputs 0 next cycle, state IDLE, no advance.
REQ-038 mux_mask changed 0101->0010 mid-window: current window finishes on old group, next window uses group 1 only.
REQ-039 XC_SCHED_OVERRUN_EN defined, 2 ticks during READOUT: overrun=1 and holds until enable toggles; undefined: overrun stays 0.
REQ-040 reset_n asserted mid-SETTLE asynchronously (between clk edges): outputs 0 immediately; after release restart from lowest mask bit.
